// File: rtl/echo_pkg.sv
// Shared defaults and state encoding for the echo frame controller.
// Imported by the controller, its frame RAM and the bench.
package echo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    RECV = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/echo_frame_ram.sv
// Single-port frame buffer: synchronous write, registered read.
// Read register only updates when re is high, so the word holds.
module echo_frame_ram
  import echo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and held read register share the single address.
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/echo_frame_ctrl.sv
// Collects a zero-terminated frame, then echoes it word by word.
// Overflowing words are dropped and flagged until the echo ends.
module echo_frame_ctrl
  import echo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ack,
  output logic [ADDR_W:0]   frame_len,
  output logic              overflow,
  output logic              frame_done
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_t state, state_nx;

  logic [ADDR_W:0]   rd_idx;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              accept;
  logic              is_term;
  logic              full;
  logic              last;
  logic              ram_we;
  logic              ram_re;
  logic              done_set;

  assign accept   = rx_valid && (state == RECV);
  assign is_term  = (rx_data == '0);
  assign full     = (frame_len == FULL);
  assign last     = ((rd_idx + ONE) == frame_len);
  assign ram_we   = accept && !is_term && !full;
  assign ram_re   = (state == LOAD);
  assign ram_addr = (state == RECV) ? frame_len[ADDR_W-1:0]
                                    : rd_idx[ADDR_W-1:0];
  assign tx_data  = tx_valid ? ram_rdata : '0;

  echo_frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (rx_data),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RECV;
    else
      state <= state_nx;
  end

  // Next state, handshake outputs and frame_done request.
  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    done_set = 1'b0;
    unique case (state)
      RECV: begin
        rx_ready = 1'b1;
        if (accept && is_term) begin
          if (frame_len == '0)
            done_set = 1'b1;
          else
            state_nx = LOAD;
        end
      end
      LOAD: begin
        state_nx = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ack) begin
          done_set = last;
          state_nx = last ? RECV : LOAD;
        end
      end
      default: begin
        state_nx = RECV;
      end
    endcase
  end

  // Frame length, read index, sticky overflow and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_len  <= '0;
      rd_idx     <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_set;
      if (ram_we)
        frame_len <= frame_len + ONE;
      if (accept && !is_term && full)
        overflow <= 1'b1;
      if ((state == SEND) && tx_ack) begin
        if (last) begin
          frame_len <= '0;
          rd_idx    <= '0;
          overflow  <= 1'b0;
        end else begin
          rd_idx <= rd_idx + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_frame_ctrl.sv
// Directed bench for echo_frame_ctrl.
// Expected words and flags are written out by hand per scenario.
module tb_echo_frame_ctrl;
  import echo_pkg::*;

  localparam int AW = ADDR_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ack = 1'b0;
  logic [AW:0]   frame_len;
  logic          overflow;
  logic          frame_done;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  int d0;
  logic [7:0] exp_q[$];

  echo_frame_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ack     (tx_ack),
    .frame_len  (frame_len),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (frame_done) done_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_rx(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic run_echo();
    int n;
    logic [7:0] w;
    while (exp_q.size() > 0) begin
      n = 0;
      while (!tx_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      w = exp_q.pop_front();
      chk("tx_valid", 32'(tx_valid), 32'd1);
      chk("tx_data", 32'(tx_data), 32'(w));
      chk("rx_ready_echo", 32'(rx_ready), 32'd0);
      tx_ack = 1'b1;
      @(posedge clk);
      #1;
      tx_ack = 1'b0;
      @(negedge clk);
      chk("gap_valid", 32'(tx_valid), 32'd0);
      chk("gap_data", 32'(tx_data), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    #12;
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_frame_len", 32'(frame_len), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    d0 = done_cnt;
    send_rx(8'h41);
    send_rx(8'h42);
    send_rx(8'h43);
    chk("t1_len", 32'(frame_len), 32'd3);
    send_rx(8'h00);
    @(negedge clk);
    chk("t1_load_idle", 32'(tx_valid), 32'd0);
    chk("t1_rx_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk("t1_first_tx", 32'(tx_valid), 32'd1);
    exp_q = '{8'h41, 8'h42, 8'h43};
    run_echo();
    @(negedge clk);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_len_clr", 32'(frame_len), 32'd0);

    d0 = done_cnt;
    send_rx(8'h00);
    chk("t2_done", 32'(frame_done), 32'd1);
    chk("t2_rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    chk("t2_no_tx", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("t2_done_off", 32'(frame_done), 32'd0);
    chk("t2_rx_ready2", 32'(rx_ready), 32'd1);
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    send_rx(8'h55);
    send_rx(8'h66);
    send_rx(8'h00);
    @(negedge clk);
    @(negedge clk);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = ~rx_valid;
      rx_data  = 8'h77;
      if (tx_valid !== 1'b1 || tx_data !== 8'h55) ok = 1'b0;
    end
    rx_valid = 1'b0;
    rx_data  = '0;
    chk("t3_stable", 32'(ok), 32'd1);
    chk("t3_len", 32'(frame_len), 32'd2);
    exp_q = '{8'h55, 8'h66};
    run_echo();
    @(negedge clk);
    chk("t3_len_clr", 32'(frame_len), 32'd0);

    for (int i = 1; i <= 5; i++) send_rx(8'(i));
    send_rx(8'h00);
    exp_q = '{8'h01};
    run_echo();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_tx_valid", 32'(tx_valid), 32'd0);
    chk("t4_tx_data", 32'(tx_data), 32'd0);
    chk("t4_rx_ready", 32'(rx_ready), 32'd1);
    chk("t4_len", 32'(frame_len), 32'd0);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_rx(8'h21);
    send_rx(8'h22);
    send_rx(8'h00);
    exp_q = '{8'h21, 8'h22};
    run_echo();
    @(negedge clk);
    chk("t4_len_clr", 32'(frame_len), 32'd0);

    d0 = done_cnt;
    for (int i = 0; i < 257; i++)
      send_rx(i < 256 ? 8'((i % 255) + 1) : 8'hEE);
    chk("t5_len", 32'(frame_len), 32'd256);
    chk("t5_ovf", 32'(overflow), 32'd1);
    send_rx(8'h00);
    @(negedge clk);
    chk("t5_ovf_echo", 32'(overflow), 32'd1);
    for (int i = 0; i < 256; i++) exp_q.push_back(8'((i % 255) + 1));
    run_echo();
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) ok = 1'b0;
    end
    chk("t5_no_extra", 32'(ok), 32'd1);
    chk("t5_done_cnt", 32'(done_cnt - d0), 32'd1);

    d0 = done_cnt;
    send_rx(8'h11);
    send_rx(8'h00);
    exp_q = '{8'h11};
    run_echo();
    send_rx(8'h22);
    send_rx(8'h33);
    send_rx(8'h00);
    exp_q = '{8'h22, 8'h33};
    run_echo();
    @(negedge clk);
    chk("t6_done_cnt", 32'(done_cnt - d0), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
